id_stage_regread: RTL

- Instruction-decode stage of the 5-stage RISC-V pipeline.
- Takes IF/ID contents, decodes rs1/rs2/rd and the immediate, and drives the register file read addresses.
- Captures operands, with x0 forced to zero and a same-cycle write-back bypass, into the ID/EX pipeline register.
- Detects load-use hazards: stalls IF and injects a bubble. Counts stall cycles.

---
 rtl/id_stage_regread.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_stage_regread.sv
// Instruction-decode stage: field decode, register-file read with write-back bypass,
// load-use hazard detection (stall + bubble) and a saturating stall-cycle counter.
module id_stage_regread #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_valid_i,
  input  logic [31:0]                if_instr_i,
  input  logic [DATA_WIDTH-1:0]      if_pc_i,
  input  logic                       flush_i,
  input  logic                       ex_memread_i,
  input  logic [4:0]                 ex_rd_i,
  input  logic                       wb_write_i,
  input  logic [4:0]                 wb_addr_i,
  input  logic [DATA_WIDTH-1:0]      wb_data_i,
  output logic [4:0]                 rf_out1addr_o,
  output logic [4:0]                 rf_out2addr_o,
  input  logic [DATA_WIDTH-1:0]      rf_out1_i,
  input  logic [DATA_WIDTH-1:0]      rf_out2_i,
  output logic                       stall_o,
  output logic                       ex_valid_o,
  output logic [DATA_WIDTH-1:0]      ex_pc_o,
  output logic [31:0]                ex_instr_o,
  output logic [DATA_WIDTH-1:0]      ex_rs1data_o,
  output logic [DATA_WIDTH-1:0]      ex_rs2data_o,
  output logic [DATA_WIDTH-1:0]      ex_imm_o,
  output logic [4:0]                 ex_rs1_o,
  output logic [4:0]                 ex_rs2_o,
  output logic [4:0]                 ex_rdout_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {RUN, BUBBLE} occ_state_e;

  occ_state_e                 state_q;
  logic                       ex_valid_q;
  logic [DATA_WIDTH-1:0]      ex_pc_q, ex_rs1data_q, ex_rs2data_q, ex_imm_q;
  logic [31:0]                ex_instr_q;
  logic [4:0]                 ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

  logic [6:0]            opcode;
  logic [4:0]            rs1, rs2, rd;
  logic                  rs1_used, rs2_used, hazard;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_d, rs1data_d, rs2data_d;

  assign opcode        = if_instr_i[6:0];
  assign rs1           = if_instr_i[19:15];
  assign rs2           = if_instr_i[24:20];
  assign rd            = if_instr_i[11:7];
  assign rf_out1addr_o = rs1;
  assign rf_out2addr_o = rs2;

  assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = opcode inside {OP_REG, OP_STORE, OP_BRANCH};

  assign hazard = if_valid_i && ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((rs1_used && rs1 == ex_rd_i) || (rs2_used && rs2 == ex_rd_i));
  // The load leaves EX on the next edge, so a stall never lasts beyond one cycle per hazard.
  assign stall_o = hazard && !flush_i && rst_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm32 = 32'd0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      OP_STORE:  imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      OP_BRANCH: imm32 = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                          if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {if_instr_i[31:12], 12'd0};
      OP_JAL:    imm32 = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                          if_instr_i[20], if_instr_i[30:21], 1'b0};
      default:   imm32 = 32'd0;
    endcase
  end

  assign imm_d = DATA_WIDTH'($signed(imm32));

  // The register file commits after the edge, so a same-cycle write must be forwarded.
  always_comb begin
    rs1data_d = rf_out1_i;
    if (rs1 == 5'd0)                           rs1data_d = '0;
    else if (wb_write_i && wb_addr_i == rs1)   rs1data_d = wb_data_i;
    rs2data_d = rf_out2_i;
    if (rs2 == 5'd0)                           rs2data_d = '0;
    else if (wb_write_i && wb_addr_i == rs2)   rs2data_d = wb_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments and every register is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_instr_q   <= '0;
      ex_rs1data_q <= '0;
      ex_rs2data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      stall_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        RUN:     state_q <= stall_o ? BUBBLE : RUN;
        BUBBLE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase

      if (flush_i || stall_o) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q   <= if_valid_i;
        ex_pc_q      <= if_pc_i;
        ex_instr_q   <= if_instr_i;
        ex_rs1data_q <= rs1data_d;
        ex_rs2data_q <= rs2data_d;
        ex_imm_q     <= imm_d;
        ex_rs1_q     <= rs1;
        ex_rs2_q     <= rs2;
        ex_rd_q      <= rd;
      end

      if (stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_instr_o    = ex_instr_q;
  assign ex_rs1data_o  = ex_rs1data_q;
  assign ex_rs2data_o  = ex_rs2data_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rs1_o      = ex_rs1_q;
  assign ex_rs2_o      = ex_rs2_q;
  assign ex_rdout_o    = ex_rd_q;
  assign stall_count_o = stall_cnt_q;

endmodule
